// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer for a WIDTH-bit add/subtract on one external 4-bit adder slice.
// It processes one nibble per cycle, LSB first, and uses a valid/ready handshake on each side.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    int unsigned       base;
    logic              last;

    assign base = 32'(idx_q) * 4;
    assign last = (idx_q == IDXW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                add_a   = a_q[base +: 4];
                add_b   = b_q[base +: 4];
                add_cin = carry_q;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is folded in at capture time: B is stored inverted and the carry is forced to 1.
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ? 1'b1 : op_cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                result_d[base +: 4] = add_sum;
                carry_d             = add_cout;
                idx_d               = idx_q + 1'b1;
                if (last) begin
                    idx_d  = '0;
                    cout_d = add_cout;
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a WIDTH=16 instance driven from a vector table with a scoreboard,
// plus a WIDTH=4 instance; each drives a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, op_cin = 1'b0, op_sub = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, result;
    logic        out_valid, out_ready = 1'b0, carry_out, overflow;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    logic       iv4 = 1'b0, ir4, cin4 = 1'b0, sub4 = 1'b0, ov4, or4 = 1'b0, co4, of4;
    logic [3:0] a4 = '0, b4 = '0, res4, aa4, ab4, as4;
    logic       ac4, acout4;

    assign {acout4, as4} = {1'b0, aa4} + {1'b0, ab4} + {4'b0, ac4};

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .op_a(a4), .op_b(b4), .op_cin(cin4), .op_sub(sub4),
        .out_valid(ov4), .out_ready(or4),
        .result(res4), .carry_out(co4), .overflow(of4),
        .add_a(aa4), .add_b(ab4), .add_cin(ac4),
        .add_sum(as4), .add_cout(acout4)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] res;
        logic        cout, ovf;
    } vec_t;

    vec_t       tbl[7];
    vec_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cins_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, input logic [15:0] res, input logic cout,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.res = res; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    // Full-width reference: two's-complement add of A and (optionally inverted) B.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic sub);
        logic [15:0] bb;
        logic [16:0] s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {16'b0, (sub ? 1'b1 : cin)};
        return mk(a, b, cin, sub, s[15:0], s[16], (a[15] == bb[15]) && (s[15] != a[15]));
    endfunction

    task automatic do_op(input vec_t v, input int bp);
        int k;
        logic [15:0] snap_r;
        logic        snap_c;
        vec_t        e;
        @(negedge clk);
        in_valid = 1'b1; op_a = v.a; op_b = v.b; op_cin = v.cin; op_sub = v.sub;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        cins_seen = '0;
        while (!out_valid && k < 40) begin
            if (k < 4) cins_seen[k] = add_cin;
            @(negedge clk);
            k++;
        end
        chk("latency16", 32'(k), 32'd4);
        snap_r = result;
        snap_c = carry_out;
        for (int i = 0; i < bp; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'(snap_r));
            chk("bp_carry", 32'(carry_out), 32'(snap_c));
            in_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("carry_out", 32'(carry_out), 32'(e.cout));
            chk("overflow", 32'(overflow), 32'(e.ovf));
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int k;
        tbl[0] = mk(16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0);
        tbl[1] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tbl[2] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tbl[3] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        tbl[4] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tbl[5] = mk(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        tbl[6] = mk(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        chk("rst_add_bus", {23'd0, add_a, add_b, add_cin}, 32'd0);
        chk("rst_w4_ready", 32'(ir4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i], (i == 2) ? 5 : 0);
            if (i == 1) chk("carry_chain_cin", 32'(cins_seen), 32'hE);
        end

        for (int i = 0; i < 6; i++)
            do_op(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)), i % 3);

        // Reset while the third slice is being processed.
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b1; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_add_cin", 32'(add_cin), 32'd0);
        #2;
        rst_n = 1'b1;
        do_op(mk(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0), 0);

        // WIDTH=4 instance: single-cycle RUN.
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
        chk("w4_in_ready", 32'(ir4), 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        k = 0;
        while (!ov4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("w4_latency", 32'(k), 32'd1);
        chk("w4_result", 32'(res4), 32'h1);
        chk("w4_carry", 32'(co4), 32'd1);
        chk("w4_ovf", 32'(of4), 32'd0);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("w4_post_valid", 32'(ov4), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
